// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the conv SRAM arbiter and the host-side
// register decode. It holds the ICB bus widths, the master-id encoding that
// is stored in the arbiter's ID FIFO, and the conv register map.
package conv_pkg;

   localparam int unsigned ICB_AW = 32;
   localparam int unsigned ICB_DW = 32;

   // Master ids; the 1-bit value is what the ID FIFO stores.
   typedef enum logic {
      MST_CONV = 1'b0,
      MST_HOST = 1'b1
   } mst_id_e;

   // Host-visible conv register map (byte addresses).
   localparam logic [ICB_AW-1:0] CONV_CTRL_ADDR     = 32'h0000_0000;
   localparam logic [ICB_AW-1:0] CONV_STATUS_ADDR   = 32'h0000_0004;
   localparam logic [ICB_AW-1:0] CONV_IFM_BASE_ADDR = 32'h0000_0008;
   localparam logic [ICB_AW-1:0] CONV_OFM_BASE_ADDR = 32'h0000_000C;
   localparam logic [ICB_AW-1:0] CONV_WGT_BASE_ADDR = 32'h0000_0010;
   localparam logic [ICB_AW-1:0] CONV_DIM_ADDR      = 32'h0000_0014;

endpackage

// File: rtl/conv_arb_idfifo.sv
// conv_arb_idfifo: synchronous FIFO of 1-bit master ids, one entry per
// outstanding command.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write an id (ignored while full)
//   pop        : drop the head entry (ignored while empty)
//   full/empty : occupancy flags
//   dout       : id at the head of the FIFO
module conv_arb_idfifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic dout
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   logic [DEPTH-1:0] mem_q;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr] <= din;
   end

endmodule

// File: rtl/conv_mem_arb.sv
// conv_mem_arb: two-master, one-slave ICB arbiter in front of the conv SRAM.
//   conv_icb_* : master 0 (conv core) command/response
//   host_icb_* : master 1 (host data path) command/response
//   mem_icb_*  : shared SRAM slave port
//   arb_err    : sticky, set when a response arrives with nothing outstanding
// Commands are arbitrated round-robin with the grant held while the slave
// stalls; an ID FIFO routes the in-order responses back to their owner.
module conv_mem_arb
   import conv_pkg::*;
#(
   parameter int unsigned AW         = ICB_AW,
   parameter int unsigned DW         = ICB_DW,
   parameter int unsigned OUTS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            conv_icb_cmd_valid,
   output logic            conv_icb_cmd_ready,
   input  logic [AW-1:0]   conv_icb_cmd_addr,
   input  logic            conv_icb_cmd_read,
   input  logic [DW-1:0]   conv_icb_cmd_wdata,
   input  logic [DW/8-1:0] conv_icb_cmd_wmask,
   output logic            conv_icb_rsp_valid,
   input  logic            conv_icb_rsp_ready,
   output logic [DW-1:0]   conv_icb_rsp_rdata,
   input  logic            host_icb_cmd_valid,
   output logic            host_icb_cmd_ready,
   input  logic [AW-1:0]   host_icb_cmd_addr,
   input  logic            host_icb_cmd_read,
   input  logic [DW-1:0]   host_icb_cmd_wdata,
   input  logic [DW/8-1:0] host_icb_cmd_wmask,
   output logic            host_icb_rsp_valid,
   input  logic            host_icb_rsp_ready,
   output logic [DW-1:0]   host_icb_rsp_rdata,
   output logic            mem_icb_cmd_valid,
   input  logic            mem_icb_cmd_ready,
   output logic [AW-1:0]   mem_icb_cmd_addr,
   output logic            mem_icb_cmd_read,
   output logic [DW-1:0]   mem_icb_cmd_wdata,
   output logic [DW/8-1:0] mem_icb_cmd_wmask,
   input  logic            mem_icb_rsp_valid,
   output logic            mem_icb_rsp_ready,
   input  logic [DW-1:0]   mem_icb_rsp_rdata,
   output logic            arb_err
);

   mst_id_e gnt_id;
   mst_id_e last_gnt;
   mst_id_e lock_id;
   mst_id_e head_id;
   logic    gnt_vld;
   logic    gnt_src_vld;
   logic    lock;
   logic    cmd_hs;
   logic    rsp_hs;
   logic    fifo_full;
   logic    fifo_empty;
   logic    fifo_dout;

   // Grant selection
   always_comb begin
      gnt_vld = 1'b1;
      gnt_id  = MST_CONV;
      if (lock)
         gnt_id = lock_id;
      else if (conv_icb_cmd_valid && host_icb_cmd_valid)
         gnt_id = (last_gnt == MST_CONV) ? MST_HOST : MST_CONV;
      else if (conv_icb_cmd_valid)
         gnt_id = MST_CONV;
      else if (host_icb_cmd_valid)
         gnt_id = MST_HOST;
      else
         gnt_vld = 1'b0;
   end

   // Command mux; with no grant the fields follow the conv master.
   always_comb begin
      mem_icb_cmd_addr  = conv_icb_cmd_addr;
      mem_icb_cmd_read  = conv_icb_cmd_read;
      mem_icb_cmd_wdata = conv_icb_cmd_wdata;
      mem_icb_cmd_wmask = conv_icb_cmd_wmask;
      gnt_src_vld       = conv_icb_cmd_valid;
      if (gnt_id == MST_HOST) begin
         mem_icb_cmd_addr  = host_icb_cmd_addr;
         mem_icb_cmd_read  = host_icb_cmd_read;
         mem_icb_cmd_wdata = host_icb_cmd_wdata;
         mem_icb_cmd_wmask = host_icb_cmd_wmask;
         gnt_src_vld       = host_icb_cmd_valid;
      end
      mem_icb_cmd_valid  = gnt_vld & gnt_src_vld & ~fifo_full;
      conv_icb_cmd_ready = gnt_vld & mem_icb_cmd_ready & ~fifo_full & (gnt_id == MST_CONV);
      host_icb_cmd_ready = gnt_vld & mem_icb_cmd_ready & ~fifo_full & (gnt_id == MST_HOST);
   end

   assign cmd_hs = mem_icb_cmd_valid & mem_icb_cmd_ready;

   // Response routing by the id at the FIFO head; with nothing outstanding
   // the response is accepted and dropped.
   always_comb begin
      head_id            = mst_id_e'(fifo_dout);
      conv_icb_rsp_rdata = mem_icb_rsp_rdata;
      host_icb_rsp_rdata = mem_icb_rsp_rdata;
      conv_icb_rsp_valid = mem_icb_rsp_valid & ~fifo_empty & (head_id == MST_CONV);
      host_icb_rsp_valid = mem_icb_rsp_valid & ~fifo_empty & (head_id == MST_HOST);
      if (fifo_empty)
         mem_icb_rsp_ready = 1'b1;
      else if (head_id == MST_HOST)
         mem_icb_rsp_ready = host_icb_rsp_ready;
      else
         mem_icb_rsp_ready = conv_icb_rsp_ready;
   end

   assign rsp_hs = mem_icb_rsp_valid & mem_icb_rsp_ready & ~fifo_empty;

   // Lock holds the grant (and so the muxed addr/data) across slave stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock     <= 1'b0;
         lock_id  <= MST_CONV;
         last_gnt <= MST_HOST;
         arb_err  <= 1'b0;
      end else begin
         if (cmd_hs) begin
            lock     <= 1'b0;
            last_gnt <= gnt_id;
         end else if (mem_icb_cmd_valid) begin
            lock    <= 1'b1;
            lock_id <= gnt_id;
         end
         if (mem_icb_rsp_valid && fifo_empty)
            arb_err <= 1'b1;
      end
   end

   conv_arb_idfifo #(
      .DEPTH (OUTS_DEPTH)
   ) u_idfifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_hs),
      .din   (gnt_id),
      .pop   (rsp_hs),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

endmodule

// File: tb/tb_conv_mem_arb.sv
module tb_conv_mem_arb;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        conv_icb_cmd_valid, conv_icb_cmd_ready, conv_icb_cmd_read;
   logic [31:0] conv_icb_cmd_addr, conv_icb_cmd_wdata;
   logic [3:0]  conv_icb_cmd_wmask;
   logic        conv_icb_rsp_valid, conv_icb_rsp_ready;
   logic [31:0] conv_icb_rsp_rdata;
   logic        host_icb_cmd_valid, host_icb_cmd_ready, host_icb_cmd_read;
   logic [31:0] host_icb_cmd_addr, host_icb_cmd_wdata;
   logic [3:0]  host_icb_cmd_wmask;
   logic        host_icb_rsp_valid, host_icb_rsp_ready;
   logic [31:0] host_icb_rsp_rdata;
   logic        mem_icb_cmd_valid, mem_icb_cmd_ready, mem_icb_cmd_read;
   logic [31:0] mem_icb_cmd_addr, mem_icb_cmd_wdata;
   logic [3:0]  mem_icb_cmd_wmask;
   logic        mem_icb_rsp_valid, mem_icb_rsp_ready;
   logic [31:0] mem_icb_rsp_rdata;
   logic        arb_err;

   conv_mem_arb #(
      .AW         (32),
      .DW         (32),
      .OUTS_DEPTH (DEPTH)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .conv_icb_cmd_valid (conv_icb_cmd_valid),
      .conv_icb_cmd_ready (conv_icb_cmd_ready),
      .conv_icb_cmd_addr  (conv_icb_cmd_addr),
      .conv_icb_cmd_read  (conv_icb_cmd_read),
      .conv_icb_cmd_wdata (conv_icb_cmd_wdata),
      .conv_icb_cmd_wmask (conv_icb_cmd_wmask),
      .conv_icb_rsp_valid (conv_icb_rsp_valid),
      .conv_icb_rsp_ready (conv_icb_rsp_ready),
      .conv_icb_rsp_rdata (conv_icb_rsp_rdata),
      .host_icb_cmd_valid (host_icb_cmd_valid),
      .host_icb_cmd_ready (host_icb_cmd_ready),
      .host_icb_cmd_addr  (host_icb_cmd_addr),
      .host_icb_cmd_read  (host_icb_cmd_read),
      .host_icb_cmd_wdata (host_icb_cmd_wdata),
      .host_icb_cmd_wmask (host_icb_cmd_wmask),
      .host_icb_rsp_valid (host_icb_rsp_valid),
      .host_icb_rsp_ready (host_icb_rsp_ready),
      .host_icb_rsp_rdata (host_icb_rsp_rdata),
      .mem_icb_cmd_valid  (mem_icb_cmd_valid),
      .mem_icb_cmd_ready  (mem_icb_cmd_ready),
      .mem_icb_cmd_addr   (mem_icb_cmd_addr),
      .mem_icb_cmd_read   (mem_icb_cmd_read),
      .mem_icb_cmd_wdata  (mem_icb_cmd_wdata),
      .mem_icb_cmd_wmask  (mem_icb_cmd_wmask),
      .mem_icb_rsp_valid  (mem_icb_rsp_valid),
      .mem_icb_rsp_ready  (mem_icb_rsp_ready),
      .mem_icb_rsp_rdata  (mem_icb_rsp_rdata),
      .arb_err            (arb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: the arbiter as the list of owners of outstanding
   // commands plus the round-robin / lock / error rules.
   bit          m_last = 1'b1;
   bit          m_lock = 1'b0;
   bit          m_lock_id = 1'b0;
   bit          m_err = 1'b0;
   bit          m_ids[$];
   logic [31:0] slave_q[$];
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];

   bit e_gid, e_mv, e_hs, e_mhs, e_empty;
   bit hs_c, hs_h;

   // Observation logs for the directed sequences
   int          gnt_log[$];
   int          rsp_log[$];
   logic [31:0] conv_got[$];
   int          host_rsp_seen;

   task automatic sample();
      bit gv, sv, full, cr, hr, cvr, hvr, mrr, head;
      @(negedge clk);
      full    = (m_ids.size() == DEPTH);
      e_empty = (m_ids.size() == 0);
      gv = 1'b1;
      if (m_lock) e_gid = m_lock_id;
      else if (conv_icb_cmd_valid && host_icb_cmd_valid) e_gid = !m_last;
      else if (conv_icb_cmd_valid) e_gid = 1'b0;
      else if (host_icb_cmd_valid) e_gid = 1'b1;
      else begin gv = 1'b0; e_gid = 1'b0; end
      sv   = e_gid ? host_icb_cmd_valid : conv_icb_cmd_valid;
      e_mv = gv && sv && !full;
      cr   = gv && mem_icb_cmd_ready && !full && !e_gid;
      hr   = gv && mem_icb_cmd_ready && !full && e_gid;
      e_hs = e_mv && mem_icb_cmd_ready;
      head = e_empty ? 1'b0 : m_ids[0];
      cvr  = mem_icb_rsp_valid && !e_empty && !head;
      hvr  = mem_icb_rsp_valid && !e_empty && head;
      mrr  = e_empty ? 1'b1 : (head ? host_icb_rsp_ready : conv_icb_rsp_ready);
      e_mhs = mem_icb_rsp_valid && mrr;

      chk("mem_cmd_valid", mem_icb_cmd_valid, e_mv);
      chk("conv_cmd_ready", conv_icb_cmd_ready, cr);
      chk("host_cmd_ready", host_icb_cmd_ready, hr);
      if (e_mv) begin
         chk("mem_cmd_addr", mem_icb_cmd_addr, e_gid ? host_icb_cmd_addr : conv_icb_cmd_addr);
         chk("mem_cmd_read", mem_icb_cmd_read, e_gid ? host_icb_cmd_read : conv_icb_cmd_read);
         chk("mem_cmd_wdata", mem_icb_cmd_wdata, e_gid ? host_icb_cmd_wdata : conv_icb_cmd_wdata);
         chk("mem_cmd_wmask", mem_icb_cmd_wmask, e_gid ? host_icb_cmd_wmask : conv_icb_cmd_wmask);
      end
      chk("conv_rsp_valid", conv_icb_rsp_valid, cvr);
      chk("host_rsp_valid", host_icb_rsp_valid, hvr);
      chk("mem_rsp_ready", mem_icb_rsp_ready, mrr);
      chk("arb_err", arb_err, m_err);
      if (cvr && conv_icb_rsp_ready) begin
         if (exp_q0.size() == 0) chk("conv_rsp_owed", exp_q0.size(), 1);
         else chk("conv_rdata", conv_icb_rsp_rdata, exp_q0.pop_front());
      end
      if (hvr && host_icb_rsp_ready) begin
         if (exp_q1.size() == 0) chk("host_rsp_owed", exp_q1.size(), 1);
         else chk("host_rdata", host_icb_rsp_rdata, exp_q1.pop_front());
      end

      if (mem_icb_cmd_valid && mem_icb_cmd_ready)
         gnt_log.push_back(conv_icb_cmd_ready ? 0 : (host_icb_cmd_ready ? 1 : 2));
      if (mem_icb_rsp_valid && mem_icb_rsp_ready && (conv_icb_rsp_valid || host_icb_rsp_valid))
         rsp_log.push_back(conv_icb_rsp_valid ? 0 : 1);
      if (conv_icb_rsp_valid && conv_icb_rsp_ready) conv_got.push_back(conv_icb_rsp_rdata);
      if (host_icb_rsp_valid) host_rsp_seen++;
   endtask

   task automatic advance();
      logic [31:0] a;
      @(posedge clk);
      hs_c = 1'b0;
      hs_h = 1'b0;
      if (!rst_n) begin
         m_ids.delete();
         slave_q.delete();
         exp_q0.delete();
         exp_q1.delete();
         m_last = 1'b1;
         m_lock = 1'b0;
         m_err  = 1'b0;
      end else begin
         if (e_mhs && !e_empty) void'(m_ids.pop_front());
         if (e_mhs && slave_q.size() > 0) void'(slave_q.pop_front());
         if (mem_icb_rsp_valid && e_empty) m_err = 1'b1;
         if (e_hs) begin
            hs_c = !e_gid;
            hs_h = e_gid;
            m_ids.push_back(e_gid);
            m_last = e_gid;
            m_lock = 1'b0;
            a = e_gid ? host_icb_cmd_addr : conv_icb_cmd_addr;
            slave_q.push_back(a);
            if (e_gid) exp_q1.push_back(a + 32'd1);
            else exp_q0.push_back(a + 32'd1);
         end else if (e_mv) begin
            m_lock    = 1'b1;
            m_lock_id = e_gid;
         end
      end
      #1;
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   // Slave returns rdata = addr + 1, in order.
   task automatic slave_drive(input bit want);
      if (want && slave_q.size() > 0) begin
         mem_icb_rsp_valid = 1'b1;
         mem_icb_rsp_rdata = slave_q[0] + 32'd1;
      end else begin
         mem_icb_rsp_valid = 1'b0;
         mem_icb_rsp_rdata = 32'hdead_beef;
      end
   endtask

   task automatic idle_inputs();
      conv_icb_cmd_valid = 1'b0; conv_icb_cmd_addr = '0; conv_icb_cmd_read = 1'b1;
      conv_icb_cmd_wdata = '0;   conv_icb_cmd_wmask = '0; conv_icb_rsp_ready = 1'b1;
      host_icb_cmd_valid = 1'b0; host_icb_cmd_addr = '0; host_icb_cmd_read = 1'b1;
      host_icb_cmd_wdata = '0;   host_icb_cmd_wmask = '0; host_icb_rsp_ready = 1'b1;
      mem_icb_cmd_ready  = 1'b0;
      mem_icb_rsp_valid  = 1'b0; mem_icb_rsp_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      gnt_log.delete();
      rsp_log.delete();
      conv_got.delete();
      host_rsp_seen = 0;
   endtask

   task automatic drain(input int n);
      conv_icb_cmd_valid = 1'b0;
      host_icb_cmd_valid = 1'b0;
      mem_icb_cmd_ready  = 1'b1;
      conv_icb_rsp_ready = 1'b1;
      host_icb_rsp_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         slave_drive(1'b1);
         tick();
      end
      slave_drive(1'b0);
   endtask

   typedef struct {
      bit          cv, hv, mr, rv;
      bit          e_mv, e_cr, e_hr;
      logic [31:0] e_addr;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[8];
      int          alt[4];
      logic [31:0] rd_exp[3];
      int unsigned issued, kc, kh;
      bit          pc, ph;

      vecs[0] = '{0, 0, 1, 1, 0, 0, 0, 32'h100};
      vecs[1] = '{1, 0, 1, 0, 1, 1, 0, 32'h100};
      vecs[2] = '{0, 1, 1, 1, 1, 0, 1, 32'h200};
      vecs[3] = '{1, 1, 1, 0, 1, 1, 0, 32'h100};
      vecs[4] = '{1, 1, 0, 1, 1, 0, 0, 32'h100};
      vecs[5] = '{0, 1, 0, 0, 1, 0, 0, 32'h200};
      vecs[6] = '{1, 0, 0, 1, 1, 0, 0, 32'h100};
      vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 32'h100};
      alt     = '{0, 1, 0, 1};
      rd_exp  = '{32'h1, 32'h5, 32'h9};

      // Table vectors applied while reset is held: state stays at its reset
      // values, so conv wins contention and responses are dropped.
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      conv_icb_cmd_addr = 32'h100;
      host_icb_cmd_addr = 32'h200;
      for (int i = 0; i < 8; i++) begin
         conv_icb_cmd_valid = vecs[i].cv;
         host_icb_cmd_valid = vecs[i].hv;
         mem_icb_cmd_ready  = vecs[i].mr;
         mem_icb_rsp_valid  = vecs[i].rv;
         sample();
         chk("vec_mem_valid", mem_icb_cmd_valid, vecs[i].e_mv);
         chk("vec_conv_ready", conv_icb_cmd_ready, vecs[i].e_cr);
         chk("vec_host_ready", host_icb_cmd_ready, vecs[i].e_hr);
         if (vecs[i].e_mv) chk("vec_addr", mem_icb_cmd_addr, vecs[i].e_addr);
         chk("vec_rsp_any", conv_icb_rsp_valid | host_icb_rsp_valid, 0);
         chk("vec_mem_rsp_ready", mem_icb_rsp_ready, 1);
         chk("vec_arb_err", arb_err, 0);
         advance();
      end

      // Single master: conv reads 0x0, 0x4, 0x8
      do_reset();
      mem_icb_cmd_ready = 1'b1;
      issued = 0;
      for (int c = 0; c < 8; c++) begin
         conv_icb_cmd_valid = (issued < 3);
         conv_icb_cmd_addr  = 32'(issued * 4);
         slave_drive(1'b1);
         tick();
         if (hs_c) issued++;
      end
      chk("single_rsp_count", conv_got.size(), 3);
      for (int i = 0; i < 3; i++)
         chk("single_rdata", (i < conv_got.size()) ? conv_got[i] : 32'hx, rd_exp[i]);
      chk("single_host_quiet", host_rsp_seen, 0);

      // Contention right after reset
      do_reset();
      mem_icb_cmd_ready = 1'b1;
      kc = 0; kh = 0;
      for (int c = 0; c < 4; c++) begin
         conv_icb_cmd_valid = 1'b1;
         host_icb_cmd_valid = 1'b1;
         conv_icb_cmd_addr  = 32'h1000 + 32'(kc * 4);
         host_icb_cmd_addr  = 32'h2000 + 32'(kh * 4);
         slave_drive(1'b1);
         tick();
         if (hs_c) kc++;
         if (hs_h) kh++;
      end
      drain(4);
      chk("cont_gnt_count", gnt_log.size(), 4);
      chk("cont_rsp_count", rsp_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("cont_gnt", (i < gnt_log.size()) ? gnt_log[i] : 9, alt[i]);
         chk("cont_rsp_owner", (i < rsp_log.size()) ? rsp_log[i] : 9, alt[i]);
      end

      // Slave backpressure holds the host grant and address
      do_reset();
      host_icb_cmd_valid = 1'b1;
      host_icb_cmd_addr  = 32'h2A0;
      for (int c = 0; c < 3; c++) begin
         sample();
         chk("lock_addr", mem_icb_cmd_addr, 32'h2A0);
         chk("lock_conv_ready", conv_icb_cmd_ready, 0);
         advance();
         conv_icb_cmd_valid = 1'b1;
         conv_icb_cmd_addr  = 32'h1A0;
      end
      mem_icb_cmd_ready = 1'b1;
      sample();
      chk("lock_host_hs", host_icb_cmd_ready, 1);
      advance();
      host_icb_cmd_valid = 1'b0;
      sample();
      chk("lock_conv_next", conv_icb_cmd_ready, 1);
      chk("lock_conv_addr", mem_icb_cmd_addr, 32'h1A0);
      advance();
      drain(4);

      // Full: 4 outstanding, 5th blocked even with a simultaneous pop
      do_reset();
      mem_icb_cmd_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         conv_icb_cmd_valid = 1'b1;
         conv_icb_cmd_addr  = 32'h40 + 32'(c * 4);
         slave_drive(1'b0);
         tick();
      end
      conv_icb_cmd_addr = 32'h50;
      sample();
      chk("full_blocked", conv_icb_cmd_ready, 0);
      advance();
      slave_drive(1'b1);
      sample();
      chk("full_blocked_pop", conv_icb_cmd_ready, 0);
      chk("full_pop_rsp", conv_icb_rsp_valid, 1);
      advance();
      slave_drive(1'b0);
      sample();
      chk("full_accept_at_3", conv_icb_cmd_ready, 1);
      advance();
      drain(6);

      // Response backpressure: host at head, conv response waits behind it
      do_reset();
      mem_icb_cmd_ready  = 1'b1;
      host_icb_cmd_valid = 1'b1;
      host_icb_cmd_addr  = 32'h300;
      tick();
      host_icb_cmd_valid = 1'b0;
      conv_icb_cmd_valid = 1'b1;
      conv_icb_cmd_addr  = 32'h310;
      tick();
      conv_icb_cmd_valid = 1'b0;
      host_icb_rsp_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         slave_drive(1'b1);
         sample();
         chk("rbp_mem_ready", mem_icb_rsp_ready, 0);
         chk("rbp_host_valid", host_icb_rsp_valid, 1);
         chk("rbp_conv_wait", conv_icb_rsp_valid, 0);
         advance();
      end
      host_icb_rsp_ready = 1'b1;
      slave_drive(1'b1);
      sample();
      chk("rbp_release", mem_icb_rsp_ready, 1);
      advance();
      slave_drive(1'b1);
      sample();
      chk("rbp_conv_valid", conv_icb_rsp_valid, 1);
      chk("rbp_conv_rdata", conv_icb_rsp_rdata, 32'h311);
      advance();
      drain(2);

      // Error and reset, including a reset with a command outstanding
      do_reset();
      mem_icb_cmd_ready  = 1'b1;
      conv_icb_cmd_valid = 1'b1;
      conv_icb_cmd_addr  = 32'h500;
      tick();
      conv_icb_cmd_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      mem_icb_rsp_valid = 1'b1;
      mem_icb_rsp_rdata = 32'h501;
      sample();
      chk("err_drop_ready", mem_icb_rsp_ready, 1);
      chk("err_no_route", conv_icb_rsp_valid | host_icb_rsp_valid, 0);
      chk("err_not_yet", arb_err, 0);
      advance();
      mem_icb_rsp_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         sample();
         chk("err_sticky", arb_err, 1);
         advance();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sample();
      chk("err_cleared", arb_err, 0);
      advance();

      // Randomized traffic against the model
      do_reset();
      pc = 1'b0;
      ph = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!pc && ($urandom % 2 == 0)) begin
            pc = 1'b1;
            conv_icb_cmd_addr  = $urandom;
            conv_icb_cmd_read  = 1'($urandom);
            conv_icb_cmd_wdata = $urandom;
            conv_icb_cmd_wmask = 4'($urandom);
         end
         if (!ph && ($urandom % 2 == 0)) begin
            ph = 1'b1;
            host_icb_cmd_addr  = $urandom;
            host_icb_cmd_read  = 1'($urandom);
            host_icb_cmd_wdata = $urandom;
            host_icb_cmd_wmask = 4'($urandom);
         end
         conv_icb_cmd_valid = pc;
         host_icb_cmd_valid = ph;
         mem_icb_cmd_ready  = ($urandom % 4 != 0);
         conv_icb_rsp_ready = ($urandom % 4 != 0);
         host_icb_rsp_ready = ($urandom % 4 != 0);
         slave_drive(1'($urandom));
         tick();
         if (hs_c) pc = 1'b0;
         if (hs_h) ph = 1'b0;
      end
      drain(12);
      chk("rand_conv_all_rsp", exp_q0.size(), 0);
      chk("rand_host_all_rsp", exp_q1.size(), 0);
      chk("rand_no_err", arb_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
